// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver: a 14-bit binary value is
// converted to BCD by a serial double-dabble and scanned with leading-zero blanking.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] bin_in,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  digit,
  output logic [3:0]  anode
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [3:0]    LAST_ITER = 4'd13;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t          state, state_nxt;
  logic [3:0]      iter;
  logic [13:0]     bin_sr;
  logic [15:0]     bcd_sr;
  logic [15:0]     disp;
  logic [PW-1:0]   pre;
  logic [1:0]      slot;
  logic [3:0]      blank;
  logic [29:0]     step;

  function automatic logic [13:0] saturate(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift left.
  function automatic logic [29:0] dabble_step(input logic [15:0] b, input logic [13:0] s);
    logic [15:0] adj;
    for (int n = 0; n < 4; n++) begin
      adj[n*4 +: 4] = (b[n*4 +: 4] >= 4'd5) ? b[n*4 +: 4] + 4'd3 : b[n*4 +: 4];
    end
    return {adj[14:0], s, 1'b0};
  endfunction

  assign step = dabble_step(bcd_sr, bin_sr);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (iter == LAST_ITER) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      iter  <= 4'd0;
      busy  <= 1'b0;
      disp  <= 16'h0000;
    end else begin
      state <= state_nxt;
      busy  <= (state == SHIFT);
      if (state == IDLE)  iter <= 4'd0;
      if (state == SHIFT) iter <= iter + 4'd1;
      if (state == COMMIT) disp <= bcd_sr;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && load) begin
      bin_sr <= saturate(bin_in);
      bcd_sr <= 16'h0000;
    end else if (state == SHIFT) begin
      {bcd_sr, bin_sr} <= step;
    end
  end

  // Scan stage: prescaler and slot index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      slot <= 2'd0;
    end else if (pre == PRE_LAST) begin
      pre  <= '0;
      slot <= slot + 2'd1;
    end else begin
      pre  <= pre + 1'b1;
    end
  end

  always_comb begin
    blank = 4'b0000;
    if (LZ_BLANK != 0) begin
      blank[3] = (disp[15:12] == 4'd0);
      blank[2] = blank[3] && (disp[11:8] == 4'd0);
      blank[1] = blank[2] && (disp[7:4] == 4'd0);
    end
  end

  // Output stage: registered digit code and anode enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'h0;
      anode <= 4'b1111;
    end else begin
      digit <= disp[{slot, 2'b00} +: 4];
      anode <= blank[slot] ? 4'b1111 : ~(4'b0001 << slot);
    end
  end

endmodule
